// File: rtl/dotprod_seq_pkg.sv
// Shared FSM encoding for the dot-product sequencer.
// Pure definitions: no latency, no backpressure.
package dotprod_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_e;

endpackage

// File: rtl/dotprod_seq_if.sv
// Operand, multiply-add and result signals of the dot-product sequencer.
// Master drives requests and the multiply-add result; slave is the sequencer.
interface dotprod_seq_if #(
    parameter int N     = 8,
    parameter int M     = 24,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [N-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic [M-1:0]     mul_c;
    logic [M-1:0]     mul_result;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     out_result;
    logic             busy;

    modport master (
        output start, len, in_valid, in_a, in_b, mul_result, out_ready,
        input  in_ready, mul_a, mul_b, mul_c, out_valid, out_result, busy
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, mul_result, out_ready,
        output in_ready, mul_a, mul_b, mul_c, out_valid, out_result, busy
    );

endinterface

// File: rtl/dotprod_seq.sv
// Streams (a,b) pairs through an external multiply-add, accumulating sum(a*b) mod 2^M.
// One term/cycle; result valid the cycle after the last term, held until out_ready.
module dotprod_seq
    import dotprod_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 24,
    parameter int LEN_W = 8
) (
    input logic           clk,
    input logic           nreset,
    dotprod_seq_if.slave  bus
);

    state_e           state_q, state_d;
    logic [M-1:0]     acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             in_hs;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        in_hs   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    if (bus.len != '0) begin
                        count_d = bus.len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                in_hs = bus.in_valid;
                if (in_hs) begin
                    acc_d   = bus.mul_result;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // acc is left alone so the last sum stays observable until the next start
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == ST_RUN);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.mul_a      = bus.in_a;
    assign bus.mul_b      = bus.in_b;
    assign bus.mul_c      = acc_q;
    assign bus.out_result = acc_q;

endmodule

// File: tb/tb_dotprod_seq.sv
// Directed bench for dotprod_seq with a behavioural multiply-add (N=8, M=16).
module tb_dotprod_seq;

    localparam int N     = 8;
    localparam int M     = 16;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dotprod_seq_if #(.N(N), .M(M), .LEN_W(LEN_W)) bus ();

    dotprod_seq #(.N(N), .M(M), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.mul_result = M'(bus.mul_a) * M'(bus.mul_b) + bus.mul_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic term(input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic begin_op(input logic [7:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // reset state
        tick();
        chk("rst_in_ready",   32'(bus.in_ready),   0);
        chk("rst_out_valid",  32'(bus.out_valid),  0);
        chk("rst_busy",       32'(bus.busy),       0);
        chk("rst_out_result", 32'(bus.out_result), 0);
        chk("rst_mul_c",      32'(bus.mul_c),      0);
        nreset = 1'b1;
        tick();

        // basic back-to-back: 2*3+4*5+6*7 = 68
        begin_op(8'd3);
        chk("basic_in_ready", 32'(bus.in_ready), 1);
        chk("basic_busy",     32'(bus.busy),     1);
        bus.in_valid = 1'b1; bus.in_a = 8'd2; bus.in_b = 8'd3;
        #1;
        chk("basic_mul_a", 32'(bus.mul_a), 2);
        chk("basic_mul_b", 32'(bus.mul_b), 3);
        chk("basic_mul_c0", 32'(bus.mul_c), 0);
        tick();
        chk("basic_out_valid_early", 32'(bus.out_valid), 0);
        bus.in_a = 8'd4; bus.in_b = 8'd5;
        tick();
        bus.in_a = 8'd6; bus.in_b = 8'd7;
        tick();
        bus.in_valid = 1'b0;
        chk("basic_out_valid",  32'(bus.out_valid),  1);
        chk("basic_out_result", 32'(bus.out_result), 68);
        chk("basic_done_in_rdy", 32'(bus.in_ready),  0);
        finish_op();
        chk("basic_idle_valid", 32'(bus.out_valid),  0);
        chk("basic_idle_busy",  32'(bus.busy),       0);
        chk("basic_acc_kept",   32'(bus.out_result), 68);

        // backpressure: input gaps and a stalled consumer
        begin_op(8'd3);
        tick();
        tick();
        chk("bp_gap_hold", 32'(bus.mul_c), 0);
        term(8'd2, 8'd3);
        tick();
        chk("bp_acc_6", 32'(bus.mul_c), 6);
        term(8'd4, 8'd5);
        tick();
        term(8'd6, 8'd7);
        bus.in_valid = 1'b1; bus.in_a = 8'd9; bus.in_b = 8'd9;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held",  32'(bus.out_valid),  1);
            chk("bp_result_held", 32'(bus.out_result), 68);
            chk("bp_no_accept",   32'(bus.in_ready),   0);
            tick();
        end
        bus.in_valid = 1'b0;
        finish_op();
        chk("bp_released", 32'(bus.out_valid), 0);

        // start ignored during RUN and DONE
        begin_op(8'd2);
        bus.start = 1'b1; bus.len = 8'd9;
        term(8'd1, 8'd1);
        bus.start = 1'b0;
        term(8'd2, 8'd2);
        chk("ign_done",   32'(bus.out_valid),  1);
        chk("ign_result", 32'(bus.out_result), 5);
        bus.start = 1'b1; bus.len = 8'd9;
        tick();
        chk("ign_done_held",   32'(bus.out_valid),  1);
        chk("ign_result_held", 32'(bus.out_result), 5);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start = 1'b0; bus.len = '0;
        chk("ign_hs_idle", 32'(bus.busy), 0);
        tick();
        chk("ign_still_idle", 32'(bus.busy), 0);

        // back-to-back independent operation
        begin_op(8'd1);
        term(8'd10, 8'd10);
        chk("b2b_result", 32'(bus.out_result), 100);
        finish_op();

        // len=0 goes straight to DONE with a cleared sum
        bus.in_valid = 1'b1; bus.in_a = 8'd7; bus.in_b = 8'd7;
        begin_op(8'd0);
        chk("len0_valid",    32'(bus.out_valid),  1);
        chk("len0_result",   32'(bus.out_result), 0);
        chk("len0_in_ready", 32'(bus.in_ready),   0);
        bus.in_valid = 1'b0;
        finish_op();
        chk("len0_idle", 32'(bus.out_valid), 0);

        // accumulator wrap: 2*65025 mod 65536
        begin_op(8'd2);
        term(8'd255, 8'd255);
        term(8'd255, 8'd255);
        chk("wrap_result", 32'(bus.out_result), 64514);
        finish_op();

        // asynchronous reset mid-RUN
        begin_op(8'd4);
        term(8'd1, 8'd2);
        term(8'd3, 8'd4);
        chk("rstmid_acc", 32'(bus.mul_c), 14);
        #2 nreset = 1'b0;
        #1;
        chk("rstmid_in_ready",  32'(bus.in_ready),  0);
        chk("rstmid_out_valid", 32'(bus.out_valid), 0);
        chk("rstmid_busy",      32'(bus.busy),      0);
        chk("rstmid_mul_c",     32'(bus.mul_c),     0);
        tick();
        nreset = 1'b1;
        tick();
        chk("rstmid_no_valid", 32'(bus.out_valid), 0);
        begin_op(8'd1);
        term(8'd3, 8'd4);
        chk("rstmid_valid",  32'(bus.out_valid),  1);
        chk("rstmid_result", 32'(bus.out_result), 12);
        finish_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
